// File: rtl/md5_input_buf_pkg.sv
// Shared types and helpers for the MD5 input block buffer.
package md5_input_buf_pkg;

  // Lifecycle of one (context, sequence) block slot.
  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_e;

  // Bit positions inside the per-block opcode.
  localparam int BLK_OP_IF_NEW_CTX      = 0;
  localparam int BLK_OP_END_COMP_OUTPUT = 1;

  // A message block is sixteen 32-bit words.
  localparam int WORDS_PER_BLK = 16;

  // Flat slot number for a (context, sequence) pair.
  function automatic int unsigned slot_idx(input int unsigned ctx,
                                           input int unsigned seq,
                                           input int unsigned n_seq);
    return ctx * n_seq + seq;
  endfunction

endpackage

// File: rtl/md5_input_slot_fsm.sv
// Per-slot state machine: EMPTY -> FILLING -> FULL -> EMPTY.
// Error pulses are combinational so the top can fold them into the sticky
// error register on the same clock edge that drops the offending access.
module md5_input_slot_fsm
  import md5_input_buf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_hit,
  input  logic        commit,
  input  logic        rel_hit,
  output slot_state_e state,
  output logic        err_wr,
  output logic        err_rel
);

  // Slot lifecycle; release of a FULL slot wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      case (state)
        SLOT_EMPTY, SLOT_FILLING: begin
          if (wr_hit) state <= commit ? SLOT_FULL : SLOT_FILLING;
        end
        SLOT_FULL: begin
          if (rel_hit) state <= SLOT_EMPTY;
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign err_wr  = wr_hit & (state == SLOT_FULL);
  assign err_rel = rel_hit & (state != SLOT_FULL);

endmodule

// File: rtl/md5_input_buf.sv
// Input block buffer for the MD5 core: one 16x32 block per (ctx, seq) slot,
// word-wise loader writes, registered random-access reads, explicit release,
// overwrite protection and sticky error flags.
//
// Handshake: the loader owns a slot while ready[slot]=1 and hands it over by
// asserting set_input_ready together with wr_en on the last word; the core
// owns it while loaded[slot]=1 and hands it back by pulsing release_req with
// rd_ctx/rd_seq addressing the slot. There is no backpressure; every accepted
// access completes in the cycle it is presented.
module md5_input_buf
  import md5_input_buf_pkg::*;
#(
  parameter  int N_CTX    = 2,
  parameter  int N_SEQ    = 2,
  parameter  int BLK_OP_W = 2,
  localparam int N_SLOT   = N_CTX * N_SEQ,
  localparam int CW       = (N_CTX > 1) ? $clog2(N_CTX) : 1,
  localparam int SW       = (N_SEQ > 1) ? $clog2(N_SEQ) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                wr_en,
  input  logic [31:0]         din,
  input  logic [3:0]          wr_addr,
  input  logic [CW-1:0]       input_ctx,
  input  logic [SW-1:0]       input_seq,
  input  logic [BLK_OP_W-1:0] input_blk_op,
  input  logic                set_input_ready,
  output logic [N_SLOT-1:0]   ready,
  output logic [N_SLOT-1:0]   loaded,
  input  logic                rd_en,
  input  logic [CW-1:0]       rd_ctx,
  input  logic [SW-1:0]       rd_seq,
  input  logic [3:0]          rd_addr,
  output logic [31:0]         dout,
  output logic [BLK_OP_W-1:0] dout_blk_op,
  output logic                dout_valid,
  input  logic                release_req,
  output logic [1:0]          err,
  input  logic                err_clr,
  output logic [2*N_SLOT-1:0] slot_state
);

  localparam int SLW   = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int DEPTH = N_SLOT * WORDS_PER_BLK;

  logic                wr_ok;
  logic                rd_ok;
  logic [SLW-1:0]      wr_slot;
  logic [SLW-1:0]      rd_slot;
  logic                wr_accept;
  slot_state_e         state    [N_SLOT];
  logic [N_SLOT-1:0]   err_wr_v;
  logic [N_SLOT-1:0]   err_rel_v;
  logic [BLK_OP_W-1:0] blk_op_q [N_SLOT];
  logic [31:0]         mem      [DEPTH];

  // Out-of-range indices are silently ignored rather than aliased.
  assign wr_ok   = (32'(input_ctx) < N_CTX) && (32'(input_seq) < N_SEQ);
  assign rd_ok   = (32'(rd_ctx) < N_CTX) && (32'(rd_seq) < N_SEQ);
  assign wr_slot = SLW'(slot_idx(32'(input_ctx), 32'(input_seq), N_SEQ));
  assign rd_slot = SLW'(slot_idx(32'(rd_ctx), 32'(rd_seq), N_SEQ));

  // A write lands in memory only while the slot is still owned by the loader.
  assign wr_accept = wr_en & wr_ok & (state[wr_slot] != SLOT_FULL);

  for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
    wire wr_hit  = wr_en & wr_ok & (wr_slot == SLW'(i));
    wire rel_hit = release_req & rd_ok & (rd_slot == SLW'(i));

    md5_input_slot_fsm u_fsm (
      .clk     (CLK),
      .rst_n   (RST_N),
      .wr_hit  (wr_hit),
      .commit  (wr_hit & set_input_ready),
      .rel_hit (rel_hit),
      .state   (state[i]),
      .err_wr  (err_wr_v[i]),
      .err_rel (err_rel_v[i])
    );

    assign ready[i]            = (state[i] != SLOT_FULL);
    assign loaded[i]           = (state[i] == SLOT_FULL);
    assign slot_state[2*i +: 2] = state[i];
  end

  // Word storage; no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_accept) mem[{wr_slot, wr_addr}] <= din;
  end

  // Opcode is captured with the committing write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_SLOT; i++) blk_op_q[i] <= '0;
    end else if (wr_accept && set_input_ready) begin
      blk_op_q[wr_slot] <= input_blk_op;
    end
  end

  // Registered read port; a same-cycle write to the same word returns old data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout        <= '0;
      dout_blk_op <= '0;
      dout_valid  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (rd_en && rd_ok) begin
        dout        <= mem[{rd_slot, rd_addr}];
        dout_blk_op <= blk_op_q[rd_slot];
        dout_valid  <= (state[rd_slot] == SLOT_FULL);
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle survives the clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err <= 2'b00;
    end else begin
      err[0] <= (|err_wr_v)  | (err[0] & ~err_clr);
      err[1] <= (|err_rel_v) | (err[1] & ~err_clr);
    end
  end

endmodule

// File: tb/tb_md5_input_buf.sv
// Bench for md5_input_buf: directed test-plan steps followed by random
// traffic, all checked against a block-level reference model.
module tb_md5_input_buf;
  import md5_input_buf_pkg::*;

  localparam int N_CTX = 3;
  localparam int N_SEQ = 2;
  localparam int NS    = N_CTX * N_SEQ;
  localparam int CW    = 2;
  localparam int SW    = 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          wr_en, set_input_ready, rd_en, release_req, err_clr;
  logic [31:0]   din;
  logic [3:0]    wr_addr, rd_addr;
  logic [CW-1:0] input_ctx, rd_ctx;
  logic [SW-1:0] input_seq, rd_seq;
  logic [1:0]    input_blk_op;
  logic [NS-1:0] ready, loaded;
  logic [31:0]   dout;
  logic [1:0]    dout_blk_op;
  logic          dout_valid;
  logic [1:0]    err;
  logic [2*NS-1:0] slot_state;

  md5_input_buf #(.N_CTX(N_CTX), .N_SEQ(N_SEQ), .BLK_OP_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .din(din), .wr_addr(wr_addr),
    .input_ctx(input_ctx), .input_seq(input_seq), .input_blk_op(input_blk_op),
    .set_input_ready(set_input_ready), .ready(ready), .loaded(loaded),
    .rd_en(rd_en), .rd_ctx(rd_ctx), .rd_seq(rd_seq), .rd_addr(rd_addr),
    .dout(dout), .dout_blk_op(dout_blk_op), .dout_valid(dout_valid),
    .release_req(release_req), .err(err), .err_clr(err_clr),
    .slot_state(slot_state)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem_m   [NS][16];
  bit          known_m [NS][16];
  bit          full_m  [NS];
  logic [1:0]  op_m    [NS];
  logic [1:0]  err_m;
  logic [31:0] exp_dout;
  bit          exp_known;
  logic [1:0]  exp_op;
  logic        exp_valid;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      full_m[s] = 0;
      op_m[s]   = 2'b00;
    end
    err_m     = 2'b00;
    exp_dout  = 32'h0;
    exp_known = 1;
    exp_op    = 2'b00;
    exp_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NS-1:0] rdy_e, ld_e;
    for (int s = 0; s < NS; s++) begin
      ld_e[s]  = full_m[s];
      rdy_e[s] = !full_m[s];
    end
    if (exp_known) chk("dout", dout, exp_dout);
    chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    chk("dout_blk_op", 32'(dout_blk_op), 32'(exp_op));
    chk("err", 32'(err), 32'(err_m));
    chk("ready", 32'(ready), 32'(rdy_e));
    chk("loaded", 32'(loaded), 32'(ld_e));
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; the model is advanced from pre-edge state.
  task automatic step(input bit w, input int wc, input int ws, input int wa,
                      input logic [31:0] d, input bit sir, input logic [1:0] op,
                      input bit r, input int rc, input int rs, input int ra,
                      input bit rl, input bit cl);
    int  wsl, rsl;
    bit  wok, rok, wfull, rfull, e0, e1;
    wr_en = w; input_ctx = wc[CW-1:0]; input_seq = ws[SW-1:0];
    wr_addr = wa[3:0]; din = d; set_input_ready = sir; input_blk_op = op;
    rd_en = r; rd_ctx = rc[CW-1:0]; rd_seq = rs[SW-1:0]; rd_addr = ra[3:0];
    release_req = rl; err_clr = cl;

    wok = (wc < N_CTX) && (ws < N_SEQ);
    rok = (rc < N_CTX) && (rs < N_SEQ);
    wsl = wc * N_SEQ + ws;
    rsl = rc * N_SEQ + rs;
    wfull = wok ? full_m[wsl] : 1'b0;
    rfull = rok ? full_m[rsl] : 1'b0;

    if (r && rok) begin
      exp_known = known_m[rsl][ra];
      exp_dout  = mem_m[rsl][ra];
      exp_op    = op_m[rsl];
      exp_valid = rfull;
    end else begin
      exp_valid = 1'b0;
    end

    e0 = w && wok && wfull;
    e1 = rl && rok && !rfull;
    if (w && wok && !wfull) begin
      mem_m[wsl][wa]   = d;
      known_m[wsl][wa] = 1;
      if (sir) begin
        full_m[wsl] = 1;
        op_m[wsl]   = op;
      end
    end
    if (rl && rok && rfull) full_m[rsl] = 0;
    err_m[0] = e0 | (err_m[0] & !cl);
    err_m[1] = e1 | (err_m[1] & !cl);

    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic wr(input int c, input int s, input int a, input logic [31:0] d,
                    input bit sir, input logic [1:0] op);
    step(1, c, s, a, d, sir, op, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int c, input int s, input int a);
    step(0, 0, 0, 0, 32'h0, 0, 2'b00, 1, c, s, a, 0, 0);
  endtask

  task automatic rel(input int c, input int s);
    step(0, 0, 0, 0, 32'h0, 0, 2'b00, 0, c, s, 0, 1, 0);
  endtask

  task automatic clr();
    step(0, 0, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] blk0 [16];
  logic [31:0] blk3 [16];

  initial begin
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 16; a++) begin
        mem_m[s][a]   = 32'h0;
        known_m[s][a] = 0;
      end
    for (int a = 0; a < 16; a++) begin
      blk0[a] = 32'h0;
      blk3[a] = 32'h0;
    end
    blk0[0] = 32'h31636261; blk0[1] = 32'h35343332;
    blk0[2] = 32'h61383736; blk0[3] = 32'h00806362; blk0[14] = 32'h00000070;
    blk3[0] = 32'h65646362; blk3[1] = 32'h69686766;
    blk3[2] = 32'h6d6c6b6a; blk3[3] = 32'h71706f6e;
    blk3[4] = 32'h00806665; blk3[14] = 32'h00000090;

    wr_en = 0; din = 0; wr_addr = 0; input_ctx = 0; input_seq = 0;
    input_blk_op = 0; set_input_ready = 0; rd_en = 0; rd_ctx = 0;
    rd_seq = 0; rd_addr = 0; release_req = 0; err_clr = 0;
    model_reset();

    // Reset values.
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;

    // Load ctx0/seq0 and commit with opcode IF_NEW_CTX.
    for (int a = 0; a < 16; a++)
      wr(0, 0, a, blk0[a], a == 15, 2'(1 << BLK_OP_IF_NEW_CTX));
    chk("plan_loaded0", 32'(loaded[0]), 32'd1);
    chk("plan_ready0", 32'(ready[0]), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(0, 0, a);
      chk("plan_rd_s0", dout, blk0[a]);
      chk("plan_op_s0", 32'(dout_blk_op), 32'd1);
      chk("plan_valid_s0", 32'(dout_valid), 32'd1);
    end

    // Load slot 3 while slot 0 stays FULL.
    for (int a = 0; a < 16; a++)
      wr(1, 1, a, blk3[a], a == 15, 2'(1 << BLK_OP_END_COMP_OUTPUT));
    chk("plan_both_loaded", 32'(loaded), 32'h9);
    rd(1, 1, 4);
    chk("plan_rd_s3w4", dout, 32'h00806665);
    rd(0, 0, 1);
    chk("plan_s0_intact", dout, 32'h35343332);

    // Overwrite attempt on FULL slot 0.
    wr(0, 0, 0, 32'hDEADBEEF, 0, 2'b00);
    chk("plan_err_wr", 32'(err), 32'd1);
    rd(0, 0, 0);
    chk("plan_s0w0_kept", dout, 32'h31636261);
    clr();
    chk("plan_err_clr", 32'(err), 32'd0);

    // Release of an EMPTY slot, then a real release.
    rel(1, 0);
    chk("plan_err_rel", 32'(err), 32'd2);
    chk("plan_ready2", 32'(ready[2]), 32'd1);
    clr();
    rel(0, 0);
    chk("plan_ready0_rel", 32'(ready[0]), 32'd1);
    rd(0, 0, 0);
    chk("plan_valid_rel", 32'(dout_valid), 32'd0);

    // Error raised in the clearing cycle wins.
    step(0, 0, 0, 0, 32'h0, 0, 2'b00, 0, 1, 0, 0, 1, 1);
    chk("plan_err_vs_clr", 32'(err), 32'd2);
    clr();

    // Same-cycle release and write to FULL slot 3.
    step(1, 1, 1, 4, 32'h12345678, 0, 2'b00, 0, 1, 1, 0, 1, 0);
    chk("plan_rel_wins", 32'(loaded[3]), 32'd0);
    chk("plan_rel_wr_err", 32'(err), 32'd1);
    rd(1, 1, 4);
    chk("plan_s3w4_kept", dout, 32'h00806665);
    clr();

    // Out-of-range context: no state change, no error.
    wr(3, 0, 0, 32'hA5A5A5A5, 1, 2'b11);
    rel(3, 1);
    chk("plan_oor_err", 32'(err), 32'd0);

    // Write and read of the same word in the same cycle returns old data.
    wr(2, 0, 5, 32'h11111111, 0, 2'b00);
    step(1, 2, 0, 5, 32'h22222222, 0, 2'b00, 1, 2, 0, 5, 0, 0);
    chk("plan_rd_old", dout, 32'h11111111);

    // Reset in the middle of filling slot 1.
    for (int a = 0; a < 7; a++) wr(0, 1, a, 32'hC0DE0000 + 32'(a), 0, 2'b00);
    wr_en = 1; input_ctx = 0; input_seq = 1; wr_addr = 7; din = 32'hC0DE0007;
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("plan_rst_ready", 32'(ready), 32'h3F);
    chk("plan_rst_dout", dout, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Refill slot 1 and commit normally.
    for (int a = 0; a < 16; a++)
      wr(0, 1, a, 32'hBEEF0000 + 32'(a), a == 15, 2'b11);
    chk("plan_refill", 32'(loaded[1]), 32'd1);
    rd(0, 1, 7);
    chk("plan_refill_w7", dout, 32'hBEEF0007);
    chk("plan_refill_op", 32'(dout_blk_op), 32'd3);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/md5_input_buf.md
# md5_input_buf

Parametrised input block buffer feeding the MD5 core: holds one 16×32-bit message block per (context, sequence) slot for N_CTX×N_SEQ slots. Accepts blocks from the host-side loader word-by-word, and marks a slot loaded on `set_input_ready`. Serves random-address reads to the core and frees the slot on an explicit release. Successor to the fixed 2-context/2-sequence input stage: it adds a per-slot state machine, overwrite protection and sticky error reporting.

## Interface
- N_CTX, 2, number of contexts (≥1)
- N_SEQ, 2, sequences per context (≥1)
- BLK_OP_W, 2, width of per-block opcode (bit0 IF_NEW_CTX, bit1 END_COMP_OUTPUT)
- Derived: N_SLOT = N_CTX·N_SEQ; CW = max(1,clog2(N_CTX)); SW = max(1,clog2(N_SEQ)); slot index = ctx·N_SEQ + seq
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- wr_en  in  1  write din into slot (input_ctx,input_seq) word wr_addr
- din  in  32  write data
- wr_addr  in  4  word index 0..15
- input_ctx  in  CW  write context
- input_seq  in  SW  write sequence
- input_blk_op  in  BLK_OP_W  opcode, captured with set_input_ready
- set_input_ready  in  1  commit slot as loaded (qualified by wr_en)
- ready  out  N_SLOT  1 = slot writable (EMPTY or FILLING)
- loaded  out  N_SLOT  1 = slot FULL, awaiting core
- rd_en  in  1  core read request
- rd_ctx  in  CW / rd_seq  in  SW / rd_addr  in  4  read location
- dout  out  32  read data
- dout_blk_op  out  BLK_OP_W  opcode of slot read
- dout_valid  out  1  dout corresponds to a FULL slot
- release  in  1  core finished with slot (rd_ctx,rd_seq)
- err  out  2  sticky: [0] write to FULL slot, [1] release of non-FULL slot
- err_clr  in  1  clear err

## Operation
- Per-slot FSM, states EMPTY, FILLING, FULL; reset → EMPTY.
- EMPTY: wr_en to slot → FILLING; wr_en with set_input_ready → FULL directly.
- FILLING: wr_en stores word; wr_en with set_input_ready stores word, captures input_blk_op, → FULL.
- FULL: writes dropped (memory unchanged), err[0] set; release → EMPTY.
- release on EMPTY/FILLING: ignored, err[1] set.
- set_input_ready without wr_en: ignored.
- Same-cycle write and release to the same FULL slot: release wins (→ EMPTY); the write is dropped and err[0] is set.
- Write and read of the same word in the same cycle: dout returns the old data.
- ctx/seq indices ≥ N_CTX/N_SEQ: access ignored, no state change, no error.
- Memory: N_SLOT·16 words, one write port, one registered read port (block-RAM inferable).
- err_clr and a new error in the same cycle: the error wins.

## Timing
- Reset values: ready all 1, loaded all 0, dout 0, dout_blk_op 0, dout_valid 0, err 0.
- Read latency 1: rd_en at cycle t → dout/dout_blk_op/dout_valid valid at t+1; dout_valid = rd_en(t) & slot FULL at t.
- dout holds its value when rd_en is low; dout_valid is low on those cycles.
- ready/loaded are registered; they change the cycle after the committing write or release.
- Loader may commit a slot and start writing another slot on the next cycle; there are no stall cycles.
- A released slot accepts writes the cycle after release.
- RST_N asserted mid-fill or mid-read: all slots return to EMPTY immediately; memory contents are not cleared.

## Structure
- Package md5_input_buf_pkg: slot state enum (EMPTY/FILLING/FULL), BLK_OP bit positions, slot_idx(ctx,seq) function.
- Sub-module md5_input_slot_fsm: one instance per slot. Inputs: wr_hit, commit, rel_hit. Outputs: state, err pulses.
- Top holds memory, blk_op registers, read pipeline and err OR-reduction.

## Test plan
- Load ctx0/seq0 with 31636261,35343332,61383736,00806362, zeros, word14=00000070, commit with blk_op=01. Then → loaded[0]=1 and ready[0]=0. Read words 0..3 → dout matches one cycle after each read, dout_blk_op=01, dout_valid=1.
- Load ctx1/seq1 (slot 3) with 65646362,…,word14=00000090 while slot 0 is FULL → both loaded. Read slot 3 word4 → 00806665, and slot 0 data is unchanged.
- Write DEADBEEF to FULL slot 0 word0 → err=01, word0 still 31636261; err_clr → err=00.
- Release slot 2 while it is EMPTY → err=10, state unchanged. Release slot 0 → ready[0]=1 next cycle. Read slot 0 → dout_valid=0.
- Same-cycle release and write to FULL slot 3 → slot EMPTY, err[0]=1, word unchanged.
- Assert RST_N low mid-fill of slot 1 (word 7) → ready all 1, loaded 0, dout 0. Refill slot 1 after reset → normal commit.
